// File: rtl/mem_responder_if.sv
// Request/response bus between the CPU memory port and mem_responder.
// The master modport is the CPU side and the slave modport is the memory side.
interface mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised data memory with a valid/ready request and response handshake.
// It inserts WAIT_CYCLES wait states between accepting a request and accessing the array.
module mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    mem_responder_if.slave  bus
);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;

    logic                    we_q;
    logic [31:0]             addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    logic                    req_ready;
    logic                    hs;
    logic                    lat_en;
    logic                    acc_go;
    logic                    acc_we;
    logic [31:0]             acc_addr;
    logic [DATA_WIDTH-1:0]   acc_wdata;
    logic                    acc_err;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic                    mem_we;

    assign req_ready = (state_q == S_IDLE) && !reset;
    assign hs        = bus.req_valid && req_ready;

    // With zero wait states the access uses the live request on the accept edge.
    assign acc_err = (acc_addr[1:0] != 2'b00) || ((acc_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign acc_idx = acc_addr[ADDR_WIDTH+1:2];
    assign mem_we  = acc_go && acc_we && !acc_err;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        lat_en    = 1'b0;
        acc_go    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    lat_en = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        acc_go    = 1'b1;
                        acc_we    = bus.req_we;
                        acc_addr  = bus.req_addr;
                        acc_wdata = bus.req_wdata;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q > 4'd1) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    acc_go  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (acc_go) begin
            err_d   = acc_err;
            rdata_d = (!acc_err && !acc_we) ? mem[acc_idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lat_en) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states and one with zero wait states.
// It uses a vector table and a response scoreboard.
module tb_mem_responder;
    logic clk;
    logic reset;

    mem_responder_if #(.DATA_WIDTH(32)) ia ();
    mem_responder_if #(.DATA_WIDTH(32)) ib ();

    mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ia.slave)
    );

    mem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ib.slave)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb_q[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A full transaction on the WAIT_CYCLES=2 instance with resp_ready low until the response appears.
    task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] er, input logic ee, input string tag);
        resp_t e;
        int    n;
        e.rdata = er;
        e.err   = ee;
        sb_q.push_back(e);
        ia.req_valid  = 1'b1;
        ia.req_we     = we;
        ia.req_addr   = addr;
        ia.req_wdata  = wdata;
        ia.resp_ready = 1'b0;
        n = 0;
        while (!ia.req_ready && n < 20) begin tick(); n++; end
        check({tag, "_req_ready"}, 32'(ia.req_ready), 32'd1);
        tick();
        ia.req_valid = 1'b0;
        n = 0;
        while (!ia.resp_valid && n < 20) begin tick(); n++; end
        check({tag, "_latency"}, 32'(n), 32'd2);
        e = sb_q.pop_front();
        check({tag, "_rdata"}, ia.resp_rdata, e.rdata);
        check({tag, "_err"}, 32'(ia.resp_err), 32'(e.err));
        ia.resp_ready = 1'b1;
        tick();
        ia.resp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(ia.resp_valid), 32'd0);
        check({tag, "_done_rdata"}, ia.resp_rdata, 32'd0);
        check({tag, "_done_ready"}, 32'(ia.req_ready), 32'd1);
    endtask

    vec_t  vecs[14];
    vec_t  bvecs[6];
    resp_t e;
    int    n;

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0001, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 32'h0000_0000, 1'b1};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0001, 1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'h0F0F_F0F0, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h0F0F_F0F0, 1'b0};
        vecs[8]  = '{1'b0, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0020, 32'h5555_AAAA, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0020, 32'h0000_0000, 32'h5555_AAAA, 1'b0};
        vecs[11] = '{1'b1, 32'h0000_0012, 32'h1111_1111, 32'h0000_0000, 1'b1};
        vecs[12] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0004, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[13].addr = 32'h0000_0005;

        bvecs[0] = '{1'b1, 32'h0000_0040, 32'hCAFE_0000, 32'h0000_0000, 1'b0};
        bvecs[1] = '{1'b1, 32'h0000_0044, 32'hCAFE_0001, 32'h0000_0000, 1'b0};
        bvecs[2] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hCAFE_0000, 1'b0};
        bvecs[3] = '{1'b0, 32'h0000_0044, 32'h0000_0000, 32'hCAFE_0001, 1'b0};
        bvecs[4] = '{1'b0, 32'h0000_0041, 32'h0000_0000, 32'h0000_0000, 1'b1};
        bvecs[5] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'hCAFE_0000, 1'b0};

        reset = 1'b1;
        ia.req_valid = 1'b0; ia.req_we = 1'b0; ia.req_addr = '0; ia.req_wdata = '0; ia.resp_ready = 1'b0;
        ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_addr = '0; ib.req_wdata = '0; ib.resp_ready = 1'b0;
        tick();
        check("rst_req_ready", 32'(ia.req_ready), 32'd0);
        check("rst_resp_valid", 32'(ia.resp_valid), 32'd0);
        check("rst_rdata", ia.resp_rdata, 32'd0);
        check("rst_err", 32'(ia.resp_err), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("idle_req_ready", 32'(ia.req_ready), 32'd1);
        check("idle_resp_valid", 32'(ia.resp_valid), 32'd0);
        check("idle_rdata", ia.resp_rdata, 32'd0);

        for (int i = 0; i < 14; i++) begin
            run_a(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
                  $sformatf("vec%0d", i));
        end

        // Backpressure: hold resp_ready low while a second request is presented.
        e.rdata = 32'hDEAD_BEEF;
        e.err   = 1'b0;
        sb_q.push_back(e);
        ia.req_valid = 1'b1; ia.req_we = 1'b0; ia.req_addr = 32'h10; ia.resp_ready = 1'b0;
        tick();
        ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 32'h10; ia.req_wdata = 32'h0;
        n = 0;
        while (!ia.resp_valid && n < 20) begin tick(); n++; end
        check("bp_latency", 32'(n), 32'd2);
        e = sb_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 32'(ia.resp_valid), 32'd1);
            check($sformatf("bp_rdata%0d", i), ia.resp_rdata, e.rdata);
            check($sformatf("bp_req_ready%0d", i), 32'(ia.req_ready), 32'd0);
            tick();
        end
        ia.req_valid = 1'b0;
        ia.resp_ready = 1'b1;
        tick();
        ia.resp_ready = 1'b0;
        check("bp_release_valid", 32'(ia.resp_valid), 32'd0);
        check("bp_release_ready", 32'(ia.req_ready), 32'd1);
        run_a(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "bp_ignored");

        // Reset during WAIT aborts a pending store.
        ia.req_valid = 1'b1; ia.req_we = 1'b1; ia.req_addr = 32'h20; ia.req_wdata = 32'h1234_5678;
        tick();
        ia.req_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_req_ready", 32'(ia.req_ready), 32'd0);
        check("arst_resp_valid", 32'(ia.resp_valid), 32'd0);
        check("arst_rdata", ia.resp_rdata, 32'd0);
        check("arst_err", 32'(ia.resp_err), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("arst_idle_ready", 32'(ia.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("arst_no_resp", 32'(ia.resp_valid), 32'd0);
        run_a(1'b0, 32'h20, 32'h0, 32'h5555_AAAA, 1'b0, "arst_old");

        // Zero wait states: one accept every two cycles with both valids held high.
        ib.req_valid  = 1'b1;
        ib.resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e.rdata = bvecs[i].exp_rdata;
            e.err   = bvecs[i].exp_err;
            sb_q.push_back(e);
            ib.req_we    = bvecs[i].we;
            ib.req_addr  = bvecs[i].addr;
            ib.req_wdata = bvecs[i].wdata;
            check($sformatf("b%0d_req_ready", i), 32'(ib.req_ready), 32'd1);
            tick();
            check($sformatf("b%0d_valid", i), 32'(ib.resp_valid), 32'd1);
            check($sformatf("b%0d_busy", i), 32'(ib.req_ready), 32'd0);
            e = sb_q.pop_front();
            check($sformatf("b%0d_rdata", i), ib.resp_rdata, e.rdata);
            check($sformatf("b%0d_err", i), 32'(ib.resp_err), 32'(e.err));
            tick();
            check($sformatf("b%0d_done", i), 32'(ib.resp_valid), 32'd0);
        end
        ib.req_valid  = 1'b0;
        ib.resp_ready = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised data memory that serves load/store requests from the multicycle CPU.
- Sits on the CPU's memory port in place of the fixed-latency single-cycle data memory.
- Requests use a valid/ready handshake, and responses use a second valid/ready handshake.
- A parameterised wait-state counter models slow memory, so the CPU FSM must stall until a response arrives.

Parameters:
- ADDR_WIDTH, 10, log2 of memory depth in 32-bit words (1024 words).
- DATA_WIDTH, 32, word width in bits.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and the memory access; legal range 0..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  CPU presents a request.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address from the CPU.
- req_wdata  input  DATA_WIDTH  store data.
- resp_valid  output  1  response available.
- resp_ready  input  1  CPU consumes the response.
- resp_rdata  output  DATA_WIDTH  load data; 0 for stores and for errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Clocking and reset: one clock (clk). reset is asynchronous and active-high.
- Reset effects:
  - state goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
  - req_ready=0 while reset is high.
  - Memory array contents are not reset.
- States: IDLE, WAIT, RESP.
- req_ready = (state==IDLE) && !reset. It is combinational, with no dependency on req_valid.
- IDLE:
  - A handshake occurs on a rising edge where req_valid && req_ready.
  - On that edge, latch we, addr and wdata into internal registers.
  - If WAIT_CYCLES==0, perform the access on the same edge and go to RESP.
  - Otherwise load cnt=WAIT_CYCLES and go to WAIT.
- WAIT:
  - If cnt>1, decrement cnt on each edge.
  - On the edge where cnt==1, perform the access and go to RESP.
- Access timing: the access occurs on edge k+WAIT_CYCLES, where k is the accept edge. resp_valid is high in the cycle after that edge.
- Access rules:
  - err = (addr[1:0]!=0) || (addr[31:ADDR_WIDTH+2]!=0). Word index = addr[ADDR_WIDTH+1:2].
  - err=1: no array write; resp_rdata=0, resp_err=1.
  - Load, no error: resp_rdata = mem[index], resp_err=0.
  - Store, no error: mem[index] <= latched wdata; resp_rdata=0, resp_err=0.
- RESP:
  - resp_valid=1.
  - resp_rdata and resp_err are held stable until the handshake.
  - On the edge with resp_ready=1: go to IDLE, resp_valid=0, resp_rdata=0, resp_err=0.
- req_valid is ignored outside IDLE. req_addr, req_we and req_wdata are don't-care outside the accept edge.
- A request presented in the same cycle that a response completes is not accepted; IDLE lasts at least one cycle.
- Minimum transaction period is WAIT_CYCLES+2 cycles.
- resp_ready held high before resp_valid is legal: the response completes on the first RESP edge.
- Reset mid-operation:
  - Reset in WAIT aborts the transaction. A pending store is not written.
  - Reset in RESP discards the response. An already-performed store remains in memory.
- The latched request is never modified between acceptance and access.
- Implementation requirements: single write port; synchronous read is registered into resp_rdata; no combinational path from req_* to resp_*.

Test Plan:
- Reset then idle, WAIT_CYCLES=2 → req_ready=1, resp_valid=0, resp_rdata=0.
- Store addr=0x10, data=0xDEADBEEF accepted at edge k, resp_ready=1 → resp_valid high after edge k+2 with rdata=0, err=0. Then load from 0x10 → rdata=0xDEADBEEF after edge k'+2.
- Load addr=0x13 (misaligned) → resp_err=1, rdata=0. Store to addr=0x1000 (index 1024, out of range) → err=1, and a later load of 0x0 returns its prior value unchanged.
- Response backpressure:
  - Load from 0x10 with resp_ready=0 for 5 cycles → resp_valid and rdata=0xDEADBEEF held stable, req_ready=0, and a second req_valid is ignored.
  - Raise resp_ready → IDLE one cycle later.
- Store 0x12345678 to 0x20 with reset asserted for one cycle during WAIT → all outputs are their reset values immediately (asynchronous). A later load of 0x20 returns the old contents, not 0x12345678.
- WAIT_CYCLES=0 build: back-to-back loads with req_valid and resp_ready held at 1 → resp_valid high in the cycle after each accept edge, one accept every 2 cycles.
